peak_frame_sequencer: RTL and testbench

Per-channel frame controller that sits between the incoming AXI-Stream sample source and the two-peak detector. Each frame it clears the detector, streams samples with a generated bin index, injects zero padding so the tail samples reach the detector's evaluation tap, latches the two peaks and their indices, and presents them on a valid/ready result port. Oversized frames are truncated, flagged, and drained.

---
 rtl/peak_frame_sequencer_pkg.sv | 25 ++
 rtl/peak_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_peak_frame_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peak_frame_sequencer_pkg.sv
// Shared constants and state encoding for the peak frame sequencer and its
// two-peak detector.
package peak_frame_sequencer_pkg;

  localparam int DEF_VALUE_WIDTH  = 16;
  localparam int DEF_INDEX_WIDTH  = 12;
  // Zero-padding beats after the last sample; equals the detector's tap lag.
  localparam int DEF_FLUSH_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_FLUSH,
    ST_CAPTURE,
    ST_REPORT,
    ST_DRAIN
  } state_t;

  // Longest frame whose flush padding still fits the index range without wrap.
  function automatic int max_frame(input int index_width, input int flush_cycles);
    return (1 << index_width) - flush_cycles;
  endfunction

endpackage

// File: rtl/peak_frame_sequencer.sv
// Per-channel frame controller: clears the detector, streams indexed samples,
// pads the tail with zeros, captures both peaks and reports them.
module peak_frame_sequencer
  import peak_frame_sequencer_pkg::*;
#(
  parameter int VALUE_WIDTH  = DEF_VALUE_WIDTH,
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [VALUE_WIDTH-1:0] s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   det_aresetn,
  output logic                   det_valid,
  output logic                   det_last,
  output logic [VALUE_WIDTH-1:0] det_input,
  output logic [INDEX_WIDTH-1:0] det_index,
  input  logic [VALUE_WIDTH-1:0] det_peak1,
  input  logic [VALUE_WIDTH-1:0] det_peak2,
  input  logic [INDEX_WIDTH-1:0] det_index1,
  input  logic [INDEX_WIDTH-1:0] det_index2,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [VALUE_WIDTH-1:0] res_peak1,
  output logic [VALUE_WIDTH-1:0] res_peak2,
  output logic [INDEX_WIDTH-1:0] res_index1,
  output logic [INDEX_WIDTH-1:0] res_index2,
  output logic [INDEX_WIDTH-1:0] res_frame_len,
  output logic                   res_overflow,
  output logic [15:0]            frame_count,
  output logic                   busy
);

  localparam int MAX_FRAME = max_frame(INDEX_WIDTH, FLUSH_CYCLES);
  localparam int FLUSH_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_LEN   = INDEX_WIDTH'(MAX_FRAME - 1);
  localparam logic [FLUSH_W-1:0]     LAST_FLUSH = FLUSH_W'(FLUSH_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [INDEX_WIDTH-1:0] r_length;
  logic                   r_overflow;
  logic [FLUSH_W-1:0]     r_flush_cnt;
  logic [VALUE_WIDTH-1:0] r_res_peak1;
  logic [VALUE_WIDTH-1:0] r_res_peak2;
  logic [INDEX_WIDTH-1:0] r_res_index1;
  logic [INDEX_WIDTH-1:0] r_res_index2;
  logic [INDEX_WIDTH-1:0] r_res_len;
  logic                   r_res_overflow;
  logic [15:0]            r_frame_count;

  logic w_accept;
  logic w_len_full;
  logic w_flush_done;

  assign w_accept     = s_tvalid && s_tready;
  assign w_len_full   = (r_length == LAST_LEN);
  assign w_flush_done = (r_state == ST_FLUSH) && (r_flush_cnt == LAST_FLUSH);

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    s_tready     = 1'b0;
    det_valid    = 1'b0;
    det_input    = '0;
    det_last     = 1'b0;
    // Detector must be held in reset for as long as our own reset is high.
    det_aresetn  = !(reset || (r_state == ST_CLEAR));
    res_valid    = 1'b0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:    if (s_tvalid) w_state_next = ST_CLEAR;
      ST_CLEAR:   w_state_next = ST_RUN;
      ST_RUN: begin
        s_tready  = 1'b1;
        det_valid = s_tvalid;
        det_input = s_tdata;
        if (s_tvalid && (s_tlast || w_len_full)) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        det_valid = 1'b1;
        det_last  = w_flush_done;
        if (w_flush_done) w_state_next = ST_CAPTURE;
      end
      ST_CAPTURE: w_state_next = ST_REPORT;
      ST_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) w_state_next = r_overflow ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) w_state_next = ST_IDLE;
      end
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_index        <= '0;
      r_length       <= '0;
      r_overflow     <= 1'b0;
      r_flush_cnt    <= '0;
      r_res_peak1    <= '0;
      r_res_peak2    <= '0;
      r_res_index1   <= '0;
      r_res_index2   <= '0;
      r_res_len      <= '0;
      r_res_overflow <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_CLEAR: begin
          r_index     <= '0;
          r_length    <= '0;
          r_overflow  <= 1'b0;
          r_flush_cnt <= '0;
        end
        ST_RUN: begin
          if (w_accept) begin
            r_index  <= r_index + 1'b1;
            r_length <= r_length + 1'b1;
            if (!s_tlast && w_len_full) r_overflow <= 1'b1;
          end
        end
        ST_FLUSH: begin
          r_index     <= r_index + 1'b1;
          r_flush_cnt <= r_flush_cnt + 1'b1;
        end
        ST_CAPTURE: begin
          r_res_peak1    <= det_peak1;
          r_res_peak2    <= det_peak2;
          r_res_index1   <= det_index1;
          r_res_index2   <= det_index2;
          r_res_len      <= r_length;
          r_res_overflow <= r_overflow;
        end
        ST_REPORT: if (res_ready) r_frame_count <= r_frame_count + 1'b1;
        default: ;
      endcase
    end
  end

  assign det_index     = r_index;
  assign res_peak1     = r_res_peak1;
  assign res_peak2     = r_res_peak2;
  assign res_index1    = r_res_index1;
  assign res_index2    = r_res_index2;
  assign res_frame_len = r_res_len;
  assign res_overflow  = r_res_overflow;
  assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_peak_frame_sequencer.sv
// Self-checking bench for peak_frame_sequencer with a behavioural two-peak
// detector (tap lag of FLUSH_CYCLES) standing in for the real one.
module tb_peak_frame_sequencer;
  import peak_frame_sequencer_pkg::*;

  localparam int VW   = 16;
  localparam int IW   = 12;
  localparam int FC   = 4;
  localparam int MAXF = 4092;

  logic          clk;
  logic          reset;
  logic [VW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic          det_aresetn;
  logic          det_valid;
  logic          det_last;
  logic [VW-1:0] det_input;
  logic [IW-1:0] det_index;
  logic [VW-1:0] det_peak1, det_peak2;
  logic [IW-1:0] det_index1, det_index2;
  logic          res_valid;
  logic          res_ready;
  logic [VW-1:0] res_peak1, res_peak2;
  logic [IW-1:0] res_index1, res_index2, res_frame_len;
  logic          res_overflow;
  logic [15:0]   frame_count;
  logic          busy;

  peak_frame_sequencer #(
    .VALUE_WIDTH(VW), .INDEX_WIDTH(IW), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .det_aresetn(det_aresetn), .det_valid(det_valid), .det_last(det_last),
    .det_input(det_input), .det_index(det_index),
    .det_peak1(det_peak1), .det_peak2(det_peak2),
    .det_index1(det_index1), .det_index2(det_index2),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_peak1(res_peak1), .res_peak2(res_peak2),
    .res_index1(res_index1), .res_index2(res_index2),
    .res_frame_len(res_frame_len), .res_overflow(res_overflow),
    .frame_count(frame_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector model: samples travel FC stages before the strict-greater compare.
  logic [VW-1:0] m_pv [FC];
  logic [IW-1:0] m_pi [FC];
  logic [VW-1:0] m_p1, m_p2;
  logic [IW-1:0] m_i1, m_i2;

  always @(posedge clk or negedge det_aresetn) begin
    if (!det_aresetn) begin
      for (int i = 0; i < FC; i++) begin
        m_pv[i] <= '0;
        m_pi[i] <= '0;
      end
      m_p1 <= '0; m_p2 <= '0; m_i1 <= '0; m_i2 <= '0;
    end else if (det_valid) begin
      m_pv[0] <= det_input;
      m_pi[0] <= det_index;
      for (int i = 1; i < FC; i++) begin
        m_pv[i] <= m_pv[i-1];
        m_pi[i] <= m_pi[i-1];
      end
      if (m_pv[FC-1] > m_p1) begin
        m_p2 <= m_p1; m_i2 <= m_i1;
        m_p1 <= m_pv[FC-1]; m_i1 <= m_pi[FC-1];
      end else if (m_pv[FC-1] > m_p2) begin
        m_p2 <= m_pv[FC-1]; m_i2 <= m_pi[FC-1];
      end
    end
  end

  assign det_peak1  = m_p1;
  assign det_peak2  = m_p2;
  assign det_index1 = m_i1;
  assign det_index2 = m_i2;

  int n_last_seen = 0;
  always @(posedge clk) if (det_last === 1'b1) n_last_seen++;

  typedef struct {
    int          n;
    int          gap;
    logic [VW-1:0] base;
    int          pos_a;
    logic [VW-1:0] val_a;
    int          pos_b;
    logic [VW-1:0] val_b;
    logic [VW-1:0] e_p1;
    logic [IW-1:0] e_i1;
    logic [VW-1:0] e_p2;
    logic [IW-1:0] e_i2;
  } vec_t;

  localparam int NVEC = 6;
  vec_t  vecs [NVEC];
  int    n_cmp  = 0;
  int    n_fail = 0;
  string g_ctx  = "reset";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: actual %0d required %0d", g_ctx, name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec_val(input int k, input int i);
    if (i == vecs[k].pos_a) return vecs[k].val_a;
    if (i == vecs[k].pos_b) return vecs[k].val_b;
    return vecs[k].base;
  endfunction

  task automatic put_beat(input logic [VW-1:0] d, input logic last,
                          output int waited, output logic [IW-1:0] idx, output logic dv);
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    waited   = 0;
    @(negedge clk);
    while (!s_tready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!s_tready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL [%s] beat_accept_timeout: actual s_tready 0 required 1", g_ctx);
    end
    idx = det_index;
    dv  = det_valid;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic send_frame(input int k, output int first_wait, output int idx_err);
    int            w;
    logic [IW-1:0] idx;
    logic          dv;
    idx_err    = 0;
    first_wait = -1;
    for (int i = 0; i < vecs[k].n; i++) begin
      put_beat(vec_val(k, i), (i == vecs[k].n - 1), w, idx, dv);
      if (i == 0) first_wait = w;
      if (int'(idx) != i || dv !== 1'b1) idx_err++;
      if (i < vecs[k].n - 1)
        repeat (vecs[k].gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_res(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!res_valid && k < 40);
  endtask

  task automatic run_vec(input int k, input int hold);
    int          fw, ie, lat, l0, bad;
    logic [15:0] fc0;
    logic [VW-1:0] sp1;
    logic [IW-1:0] si1, slen;
    g_ctx     = $sformatf("vec%0d", k);
    fc0       = frame_count;
    l0        = n_last_seen;
    res_ready = (hold == 0);
    send_frame(k, fw, ie);
    check("first_accept_wait", fw, 2);
    check("det_index_seq_errs", ie, 0);
    wait_res(lat);
    check("res_valid_latency", lat, FC + 2);
    check("res_peak1", res_peak1, vecs[k].e_p1);
    check("res_index1", res_index1, vecs[k].e_i1);
    check("res_peak2", res_peak2, vecs[k].e_p2);
    check("res_index2", res_index2, vecs[k].e_i2);
    check("res_frame_len", res_frame_len, vecs[k].n);
    check("res_overflow", res_overflow, 0);
    if (hold > 0) begin
      sp1 = res_peak1; si1 = res_index1; slen = res_frame_len;
      bad = 0;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if (res_valid !== 1'b1 || s_tready !== 1'b0 || res_peak1 !== sp1 ||
            res_index1 !== si1 || res_frame_len !== slen || frame_count !== fc0) bad++;
      end
      check("hold_unstable_cycles", bad, 0);
      res_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("frame_count_inc", frame_count, fc0 + 16'd1);
    check("busy_after_report", busy, 0);
    check("res_valid_after_report", res_valid, 0);
    check("det_last_pulses", n_last_seen - l0, 1);
  endtask

  initial begin
    int            w, ie, lat, dvh;
    logic [IW-1:0] idx;
    logic          dv;
    logic [VW-1:0] d;
    logic [15:0]   fc0;

    vecs[0] = '{n:16, gap:0, base:16'd10, pos_a:5, val_a:16'd500, pos_b:12, val_b:16'd300,
                e_p1:16'd500, e_i1:12'd5, e_p2:16'd300, e_i2:12'd12};
    vecs[1] = '{n:16, gap:3, base:16'd10, pos_a:5, val_a:16'd500, pos_b:12, val_b:16'd300,
                e_p1:16'd500, e_i1:12'd5, e_p2:16'd300, e_i2:12'd12};
    vecs[2] = '{n:1, gap:0, base:16'd7, pos_a:-1, val_a:16'd0, pos_b:-1, val_b:16'd0,
                e_p1:16'd7, e_i1:12'd0, e_p2:16'd0, e_i2:12'd0};
    vecs[3] = '{n:8, gap:0, base:16'd0, pos_a:0, val_a:16'd4, pos_b:7, val_b:16'd9,
                e_p1:16'd9, e_i1:12'd7, e_p2:16'd4, e_i2:12'd0};
    vecs[4] = '{n:4, gap:1, base:16'd5, pos_a:-1, val_a:16'd0, pos_b:-1, val_b:16'd0,
                e_p1:16'd5, e_i1:12'd0, e_p2:16'd5, e_i2:12'd1};
    vecs[5] = '{n:6, gap:0, base:16'd1, pos_a:2, val_a:16'd200, pos_b:4, val_b:16'd200,
                e_p1:16'd200, e_i1:12'd2, e_p2:16'd200, e_i2:12'd4};

    reset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_det_aresetn", det_aresetn, 0);
    check("rst_det_valid", det_valid, 0);
    check("rst_det_index", det_index, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_det_aresetn", det_aresetn, 1);
    check("idle_s_tready", s_tready, 0);
    @(posedge clk); #1;

    for (int k = 0; k < NVEC; k++) run_vec(k, 0);

    // Oversized frame: truncated at MAXF, reported, then the tail drained.
    g_ctx = "overflow";
    res_ready = 1'b0;
    fc0 = frame_count;
    ie = 0;
    for (int i = 0; i < MAXF; i++) begin
      d = (i == 100) ? 16'd900 : (i == 4000) ? 16'd800 : 16'd1;
      put_beat(d, 1'b0, w, idx, dv);
      if (int'(idx) != i || dv !== 1'b1) ie++;
    end
    check("ovf_index_errs", ie, 0);
    wait_res(lat);
    check("ovf_res_valid_latency", lat, FC + 2);
    check("ovf_res_overflow", res_overflow, 1);
    check("ovf_res_frame_len", res_frame_len, MAXF);
    check("ovf_res_peak1", res_peak1, 900);
    check("ovf_res_index1", res_index1, 100);
    check("ovf_res_peak2", res_peak2, 800);
    check("ovf_res_index2", res_index2, 4000);
    check("ovf_s_tready_in_report", s_tready, 0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("ovf_frame_count", frame_count, fc0 + 16'd1);
    check("ovf_busy_in_drain", busy, 1);
    dvh = 0;
    for (int i = 0; i < 10; i++) begin
      put_beat(16'd2000, (i == 9), w, idx, dv);
      if (dv !== 1'b0 || w != 0) dvh++;
    end
    check("drain_beat_errs", dvh, 0);
    check("drain_busy_after", busy, 0);
    run_vec(0, 0);

    run_vec(3, 20);

    // Reset during FLUSH aborts the frame and wipes the held result.
    g_ctx = "reset_in_flush";
    res_ready = 1'b1;
    send_frame(0, w, ie);
    check("flush_busy", busy, 1);
    check("flush_det_valid", det_valid, 1);
    check("flush_det_input", det_input, 0);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_s_tready", s_tready, 0);
    check("abort_det_valid", det_valid, 0);
    check("abort_det_last", det_last, 0);
    check("abort_det_index", det_index, 0);
    check("abort_det_aresetn", det_aresetn, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_res_peak1", res_peak1, 0);
    check("abort_res_index1", res_index1, 0);
    check("abort_res_frame_len", res_frame_len, 0);
    check("abort_frame_count", frame_count, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_vec(0, 0);
    g_ctx = "end";
    check("final_frame_count", frame_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL [watchdog] simulation_time_limit: actual expired required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
